vid_timing_gen: RTL

- Raster timing source for the video pipeline; drives the scan interface consumed by blob_analyzer: vid_hpos, vid_vpos, vid_active_pix and vid_preload_line.
- Walks a frame of H_ACTIVE x V_ACTIVE pixels plus horizontal and vertical blanking.
- Advances one position per cycle in which pix_en is high.
- Adds a frame-start strobe and, optionally, a built-in foreground test pattern for bring-up without a camera.

---
 rtl/vid_timing_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: raster timing source for the video pipeline.
//
// Walks a frame of H_ACTIVE x V_ACTIVE pixels plus horizontal/vertical blanking, one position per
// app_clk cycle with pix_en high. All outputs are registered from the same next-state position,
// so they always describe the same raster location in the same cycle.
//
// Ports:
//   app_clk          in   system clock
//   app_rst          in   synchronous active-high reset
//   pix_en           in   advance enable (one position per enabled cycle)
//   vid_hpos         out  horizontal position, held at H_ACTIVE-1 during horizontal blank
//   vid_vpos         out  vertical position, held at V_ACTIVE-1 during vertical blank
//   vid_active_pix   out  position is inside the active area
//   vid_preload_line out  one-cycle strobe PRELOAD_LEAD positions before an active line starts
//   vid_frame_start  out  one-cycle strobe on the step into pixel (0,0)
//   foregnd_px       out  built-in test-pattern foreground pixel
//
// Optional feature: define VID_TEST_PATTERN_EN to build the foreground test pattern; otherwise
// foregnd_px is tied to 0.

module vid_timing_gen #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_BLANK      = 150,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_BLANK      = 20,
  parameter int unsigned PRELOAD_LEAD = 8
) (
  input  logic        app_clk,
  input  logic        app_rst,
  input  logic        pix_en,
  output logic [10:0] vid_hpos,
  output logic [10:0] vid_vpos,
  output logic        vid_active_pix,
  output logic        vid_preload_line,
  output logic        vid_frame_start,
  output logic        foregnd_px
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;

  localparam logic [10:0] HAct    = 11'(H_ACTIVE);
  localparam logic [10:0] HActM1  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] VActM1  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] VLast   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HPreld  = 11'(H_TOTAL - PRELOAD_LEAD);

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic [10:0] hpos_q, hpos_d;
  logic [10:0] vpos_q, vpos_d;
  logic        active_q, active_d;
  logic        preload_q, preload_d;
  logic        fstart_q, fstart_d;
  logic [10:0] vnext;

  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    preload_d = 1'b0;
    fstart_d  = 1'b0;
    vnext     = 11'd0;
    if (pix_en) begin
      if (hcnt_q == HLast) begin
        hcnt_d = 11'd0;
        vcnt_d = (vcnt_q == VLast) ? 11'd0 : vcnt_q + 11'd1;
      end else begin
        hcnt_d = hcnt_q + 11'd1;
      end
      // Line the preload announces: the one after the current line, modulo the frame.
      vnext     = (vcnt_d == VLast) ? 11'd0 : vcnt_d + 11'd1;
      preload_d = (hcnt_d == HPreld) && (vnext < VAct);
      fstart_d  = (hcnt_d == 11'd0) && (vcnt_d == 11'd0);
    end
    // Level outputs are recomputed from the (possibly held) next position, so they hold when idle.
    hpos_d   = (hcnt_d < HAct) ? hcnt_d : HActM1;
    vpos_d   = (vcnt_d < VAct) ? vcnt_d : VActM1;
    active_d = (hcnt_d < HAct) && (vcnt_d < VAct);
  end

`ifdef VID_TEST_PATTERN_EN
  logic fg_q, fg_d;

  always_comb begin
    fg_d = active_d && (((hpos_d >= 11'd21) && (hpos_d <= 11'd200)) ||
                        ((hpos_d >= 11'd631) && (hpos_d <= 11'd634))) &&
           (vpos_d >= 11'd6) && (vpos_d <= 11'd99);
  end

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      fg_q <= 1'b0;
    end else begin
      fg_q <= fg_d;
    end
  end

  assign foregnd_px = fg_q;
`else
  assign foregnd_px = 1'b0;
`endif

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      hcnt_q    <= HAct;
      vcnt_q    <= VLast;
      hpos_q    <= HActM1;
      vpos_q    <= VActM1;
      active_q  <= 1'b0;
      preload_q <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      active_q  <= active_d;
      preload_q <= preload_d;
      fstart_q  <= fstart_d;
    end
  end

  // Illegal parameter combinations are reported while the block is held in reset.
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      assert ((H_TOTAL <= 2047) && (V_TOTAL <= 2047) &&
              (PRELOAD_LEAD >= 1) && (PRELOAD_LEAD <= H_BLANK))
        else $error("vid_timing_gen: illegal parameter combination");
    end
  end

  assign vid_hpos         = hpos_q;
  assign vid_vpos         = vpos_q;
  assign vid_active_pix   = active_q;
  assign vid_preload_line = preload_q;
  assign vid_frame_start  = fstart_q;

endmodule
